// File: rtl/seg7_scan_decoder.sv
// Recovers four hex digits from a scanned, active-low 7-segment bus by waiting for stable samples.
// Optional macro SEG7_BLANK_DETECT_EN treats the all-off pattern as a blank digit instead of an error.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  SEG,
   input  logic [3:0]  AN,
   output logic [15:0] DIGITS,
   output logic [3:0]  DPS,
   output logic [3:0]  VALID,
   output logic [3:0]  ERR,
   output logic        FRAME_DONE
);

   typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  seg_r_q;
   logic [3:0]  an_r_q;
   logic [11:0] prev_q;
   logic [15:0] digits_q;
   logic [3:0]  dps_q, valid_q, err_q, mask_q, mask_d;
   logic        frame_done_q;

   logic [3:0]  sel;
   logic [1:0]  idx;
   logic        onehot, same, last_cnt, cap, blank;
   logic [4:0]  dec;

   // Returns {legal, value} for a 7-bit active-low segment pattern.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40: decode = 5'h10;
         7'h79: decode = 5'h11;
         7'h24: decode = 5'h12;
         7'h30: decode = 5'h13;
         7'h19: decode = 5'h14;
         7'h12: decode = 5'h15;
         7'h02: decode = 5'h16;
         7'h78: decode = 5'h17;
         7'h00: decode = 5'h18;
         7'h10: decode = 5'h19;
         7'h08: decode = 5'h1A;
         7'h03: decode = 5'h1B;
         7'h46: decode = 5'h1C;
         7'h21: decode = 5'h1D;
         7'h06: decode = 5'h1E;
         7'h0E: decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   assign sel      = ~an_r_q;
   assign onehot   = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
   assign same     = ({seg_r_q, an_r_q} == prev_q);
   assign last_cnt = (({1'b0, cnt_q} + 9'd1) >= 9'(STABLE_CYCLES));
   assign dec      = decode(seg_r_q[6:0]);

   always_comb begin
      case (sel)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         default: idx = 2'd3;
      endcase
   end

`ifdef SEG7_BLANK_DETECT_EN
   assign blank = (seg_r_q[6:0] == 7'h7F);
`else
   assign blank = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!onehot) begin
         state_d = IDLE;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = DWELL;
               cnt_d   = 8'd1;
            end
            DWELL: begin
               if (!same) begin
                  cnt_d = 8'd1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
                  if (last_cnt) state_d = HELD;
               end
            end
            HELD: begin
               if (!same) begin
                  state_d = DWELL;
                  cnt_d   = 8'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end
         endcase
      end
   end

   always_comb begin
      cap = (state_q == DWELL) && onehot && same && last_cnt;
   end

   // A capture on the clearing edge survives into the fresh mask.
   always_comb begin
      mask_d = (mask_q == 4'hF) ? 4'h0 : mask_q;
      if (cap) mask_d = mask_d | (4'b0001 << idx);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         seg_r_q      <= 8'hFF;
         an_r_q       <= 4'hF;
         prev_q       <= 12'hFFF;
         digits_q     <= 16'h0000;
         dps_q        <= 4'hF;
         valid_q      <= 4'h0;
         err_q        <= 4'h0;
         mask_q       <= 4'h0;
         frame_done_q <= 1'b0;
      end else begin
         seg_r_q      <= SEG;
         an_r_q       <= AN;
         prev_q       <= {seg_r_q, an_r_q};
         mask_q       <= mask_d;
         frame_done_q <= (mask_q == 4'hF);
         if (cap) begin
            dps_q[idx] <= seg_r_q[7];
            if (blank) begin
               valid_q[idx] <= 1'b0;
               err_q[idx]   <= 1'b0;
            end else if (dec[4]) begin
               digits_q[idx*4 +: 4] <= dec[3:0];
               valid_q[idx]         <= 1'b1;
               err_q[idx]           <= 1'b0;
            end else begin
               valid_q[idx] <= 1'b0;
               err_q[idx]   <= 1'b1;
            end
         end
      end
   end

   assign DIGITS     = digits_q;
   assign DPS        = dps_q;
   assign VALID      = valid_q;
   assign ERR        = err_q;
   assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scans push expected output events, a monitor pops them.
module tb_seg7_scan_decoder;

   localparam int SC = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  SEG;
   logic [3:0]  AN;
   logic [15:0] DIGITS;
   logic [3:0]  DPS, VALID, ERR;
   logic        FRAME_DONE;

   seg7_scan_decoder #(.STABLE_CYCLES(SC)) dut (
      .CLK(CLK), .RST(RST), .SEG(SEG), .AN(AN),
      .DIGITS(DIGITS), .DPS(DPS), .VALID(VALID), .ERR(ERR), .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          edge_n;
      logic [15:0] d;
      logic [3:0]  p, v, e;
      logic        fd;
   } ev_t;

   ev_t         q[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic        mon_en = 1'b0;
   logic [27:0] mon_last;

   logic [15:0] m_d;
   logic [3:0]  m_p, m_v, m_e, m_mask;
   logic [6:0]  pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int digit_of(input logic [3:0] a);
      case (a)
         4'b1110: digit_of = 0;
         4'b1101: digit_of = 1;
         4'b1011: digit_of = 2;
         4'b0111: digit_of = 3;
         default: digit_of = -1;
      endcase
   endfunction

   task automatic push_state(input int e, input logic fd);
      ev_t ev;
      ev.edge_n = e; ev.d = m_d; ev.p = m_p; ev.v = m_v; ev.e = m_e; ev.fd = fd;
      q.push_back(ev);
   endtask

   task automatic model_cap(input logic [7:0] s, input logic [3:0] a, input int e);
      int i;
      int val;
      i = digit_of(a);
      val = -1;
      for (int k = 0; k < 16; k++) if (pat[k] == s[6:0]) val = k;
      m_p[i] = s[7];
`ifdef SEG7_BLANK_DETECT_EN
      if (s[6:0] == 7'h7F) begin
         m_v[i] = 1'b0; m_e[i] = 1'b0;
      end else
`endif
      if (val >= 0) begin
         m_d[i*4 +: 4] = 4'(val); m_v[i] = 1'b1; m_e[i] = 1'b0;
      end else begin
         m_v[i] = 1'b0; m_e[i] = 1'b1;
      end
      m_mask[i] = 1'b1;
      push_state(e, 1'b0);
      if (m_mask == 4'hF) begin
         push_state(e + 1, 1'b1);
         m_mask = 4'h0;
      end
   endtask

   // Inputs applied just after edge cyc; first registered at cyc+1, captured SC edges later.
   task automatic apply(input logic [7:0] s, input logic [3:0] a, input int hold);
      SEG = s;
      AN  = a;
      if (digit_of(a) >= 0 && hold >= SC + 1) model_cap(s, a, cyc + 1 + SC);
      repeat (hold) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      if (m_d != 16'h0 || m_p != 4'hF || m_v != 4'h0 || m_e != 4'h0) begin
         m_d = 16'h0; m_p = 4'hF; m_v = 4'h0; m_e = 4'h0;
         push_state(cyc + 1, 1'b0);
      end
      m_mask = 4'h0;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         if ({DIGITS, DPS, VALID, ERR} !== mon_last || FRAME_DONE !== 1'b0) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event actual=%h/%h/%h/%h fd=%b required=no_event (edge %0d)",
                        DIGITS, DPS, VALID, ERR, FRAME_DONE, cyc);
            end else begin
               ev_t ev;
               ev = q.pop_front();
               chk("event_edge", 16'(cyc), 16'(ev.edge_n));
               chk("digits", DIGITS, ev.d);
               chk("dps", {12'h0, DPS}, {12'h0, ev.p});
               chk("valid", {12'h0, VALID}, {12'h0, ev.v});
               chk("err", {12'h0, ERR}, {12'h0, ev.e});
               chk("frame_done", {15'h0, FRAME_DONE}, {15'h0, ev.fd});
            end
         end
         mon_last = {DIGITS, DPS, VALID, ERR};
      end
   end

   initial begin
      RST = 1'b1; SEG = 8'hFF; AN = 4'hF;
      m_d = 16'h0; m_p = 4'hF; m_v = 4'h0; m_e = 4'h0; m_mask = 4'h0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      chk("rst_digits", DIGITS, 16'h0000);
      chk("rst_dps", {12'h0, DPS}, 16'h000F);
      chk("rst_valid", {12'h0, VALID}, 16'h0000);
      chk("rst_err", {12'h0, ERR}, 16'h0000);
      chk("rst_fd", {15'h0, FRAME_DONE}, 16'h0000);
      mon_last = {DIGITS, DPS, VALID, ERR};
      mon_en = 1'b1;

      apply(8'hC0, 4'b1110, 6);                 // digit0 = 0, DP off, nothing before edge SC
      apply(8'hF9, 4'b1110, 6);                 // frame scan 1,2,3,4
      apply(8'hA4, 4'b1101, 6);
      apply(8'hB0, 4'b1011, 6);
      apply(8'h99, 4'b0111, 6);
      apply(8'h24, 4'b1101, 3);                 // too short: 2 must never be captured
      apply(8'hB0, 4'b1101, 6);                 // digit1 captures 3
      apply(8'h92, 4'b1011, 6);                 // digit2 = 5
      apply(8'h55, 4'b1011, 6);                 // illegal: ERR, nibble stays 5, DP low
      apply(8'hC0, 4'b1100, 10);                // two digits selected: ignored
      apply(8'h40, 4'b1110, 6);                 // digit0 = 0 with DP on
      apply(8'hA4, 4'b0111, 2);                 // dwell interrupted by reset
      do_reset();
      apply(8'h7F, 4'b1110, 6);                 // blank or illegal depending on build
      apply(8'hF9, 4'b1101, 6);
      apply(8'hA4, 4'b1011, 6);
      apply(8'hB0, 4'b0111, 6);                 // completes frame including blank digit0
      SEG = 8'hFF; AN = 4'hF;
      repeat (4) @(posedge CLK);
      #1;
      chk("queue_drained", 16'(q.size()), 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
